mem_access_unit: RTL and testbench

Multicycle memory access unit sitting directly downstream of the multicycle control FSM. It consumes the control's MemRead/MemWrite strobes, the IorD-selected address and the store data. It performs an aligned byte/half/word request on a ready/ack memory bus and returns the extended load result as the memory data register (MDR) for the register write-back state. It stalls the control FSM until the access completes, faults or times out.

---
 rtl/mem_access_unit_pkg.sv | 45 ++++
 rtl/mem_access_unit_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the multicycle memory access unit.
package mem_access_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MDR_W  = 32;
  localparam int unsigned WAIT_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    DONE  = ST_DONE,
    FAULT = ST_FAULT
  } state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } bus_req_t;

  // Size encoding must be known and the address naturally aligned for it.
  function automatic logic accessLegal(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic ok;
    case (funct3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~addrLo[0];
      F3_W:        ok = (addrLo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]       storeAddrLo,
  input  logic [2:0]       storeFunct3,
  input  logic [XLEN-1:0]  storeData,
  output logic [3:0]       storeBE_c,
  output logic [XLEN-1:0]  storeWData_c,
  input  logic [1:0]       loadAddrLo,
  input  logic [2:0]       loadFunct3,
  input  logic [XLEN-1:0]  loadWord,
  output logic [MDR_W-1:0] loadData_c
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    storeBE_c    = 4'hF;
    storeWData_c = storeData;
    case (storeFunct3)
      F3_B, F3_BU: begin
        storeBE_c    = 4'b0001 << storeAddrLo;
        storeWData_c = {4{storeData[7:0]}};
      end
      F3_H, F3_HU: begin
        storeBE_c    = storeAddrLo[1] ? 4'b1100 : 4'b0011;
        storeWData_c = {2{storeData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byteLane   = 8'(loadWord >> {loadAddrLo, 3'b000});
    halfLane   = loadAddrLo[1] ? loadWord[31:16] : loadWord[15:0];
    loadData_c = MDR_W'(loadWord);
    case (loadFunct3)
      F3_B:    loadData_c = MDR_W'({{24{byteLane[7]}}, byteLane});
      F3_BU:   loadData_c = MDR_W'({24'd0, byteLane});
      F3_H:    loadData_c = MDR_W'({{16{halfLane[15]}}, halfLane});
      F3_HU:   loadData_c = MDR_W'({16'd0, halfLane});
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle memory access unit: request capture, ready/ack bus handshake,
// timeout detection and MDR capture for the control FSM's write-back state.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iMemRead,
  input  logic             iMemWrite,
  input  logic [XLEN-1:0]  iAddr,
  input  logic [XLEN-1:0]  iWData,
  input  logic [2:0]       iFunct3,
  output logic             oStall,
  output logic [MDR_W-1:0] oMDR,
  output logic             oMisalign,
  output logic             oBusErr,
  output logic             oBusReq,
  output logic             oBusWe,
  output logic [XLEN-1:0]  oBusAddr,
  output logic [3:0]       oBusBE,
  output logic [XLEN-1:0]  oBusWData,
  input  logic             iBusAck,
  input  logic [XLEN-1:0]  iBusRData
);

  state_t             state, stateD;
  logic [WAIT_W-1:0]  waitCnt, waitD;
  logic [1:0]         addrLoQ, addrLoD;
  logic [2:0]         funct3Q, funct3D;
  bus_req_t           busQ, busD;
  logic [MDR_W-1:0]   mdrD;
  logic               misD, errD, reqD;
  logic [3:0]         storeBE_c;
  logic [XLEN-1:0]    storeWData_c;
  logic [MDR_W-1:0]   loadData_c;

  // Store lanes are formed from the live request; loads use the captured offset.
  mem_lane_align uAlign (
    .storeAddrLo  (iAddr[1:0]),
    .storeFunct3  (iFunct3),
    .storeData    (iWData),
    .storeBE_c    (storeBE_c),
    .storeWData_c (storeWData_c),
    .loadAddrLo   (addrLoQ),
    .loadFunct3   (funct3Q),
    .loadWord     (iBusRData),
    .loadData_c   (loadData_c)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      waitCnt   <= '0;
      addrLoQ   <= '0;
      funct3Q   <= '0;
      busQ      <= '0;
      oMDR      <= '0;
      oMisalign <= 1'b0;
      oBusErr   <= 1'b0;
      oBusReq   <= 1'b0;
    end else begin
      state     <= stateD;
      waitCnt   <= waitD;
      addrLoQ   <= addrLoD;
      funct3Q   <= funct3D;
      busQ      <= busD;
      oMDR      <= mdrD;
      oMisalign <= misD;
      oBusErr   <= errD;
      oBusReq   <= reqD;
    end
  end

  always_comb begin
    stateD  = state;
    waitD   = waitCnt;
    addrLoD = addrLoQ;
    funct3D = funct3Q;
    busD    = busQ;
    mdrD    = oMDR;
    misD    = 1'b0;
    errD    = 1'b0;
    reqD    = 1'b0;
    case (state)
      IDLE: begin
        if (iMemRead || iMemWrite) begin
          addrLoD = iAddr[1:0];
          funct3D = iFunct3;
          if (accessLegal(iFunct3, iAddr[1:0]) && !(iMemRead && iMemWrite)) begin
            busD.we    = iMemWrite;
            busD.addr  = {iAddr[XLEN-1:2], 2'b00};
            busD.be    = iMemWrite ? storeBE_c : 4'hF;
            busD.wdata = storeWData_c;
            waitD      = '0;
            reqD       = 1'b1;
            stateD     = REQ;
          end else begin
            misD   = 1'b1;
            stateD = FAULT;
          end
        end
      end
      REQ: begin
        if (iBusAck) begin
          if (!busQ.we) mdrD = loadData_c;
          stateD = DONE;
        end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
          waitD  = waitCnt + WAIT_W'(1);
          errD   = 1'b1;
          stateD = FAULT;
        end else begin
          waitD = waitCnt + WAIT_W'(1);
          reqD  = 1'b1;
        end
      end
      DONE:    stateD = IDLE;
      FAULT:   stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Stall is combinational so the control FSM freezes in the request cycle itself.
  assign oStall = !iRST && (((state == IDLE) && (iMemRead || iMemWrite)) || (state == REQ));

  assign oBusWe    = busQ.we;
  assign oBusAddr  = busQ.addr;
  assign oBusBE    = busQ.be;
  assign oBusWData = busQ.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scripted ready/ack slave.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned TO    = 4;
  localparam int          BOUND = 40;

  logic        iCLK, iRST, iMemRead, iMemWrite, iBusAck;
  logic [31:0] iAddr, iWData, iBusRData;
  logic [2:0]  iFunct3;
  logic        oStall, oMisalign, oBusErr, oBusReq, oBusWe;
  logic [31:0] oMDR, oBusAddr, oBusWData;
  logic [3:0]  oBusBE;

  int checks   = 0;
  int failures = 0;

  logic        stall0, capWe, reqAll;
  logic [31:0] capAddr, capWData;
  logic [3:0]  capBE;
  int          lat, reqCycles;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .iAddr(iAddr), .iWData(iWData), .iFunct3(iFunct3), .oStall(oStall),
    .oMDR(oMDR), .oMisalign(oMisalign), .oBusErr(oBusErr), .oBusReq(oBusReq),
    .oBusWe(oBusWe), .oBusAddr(oBusAddr), .oBusBE(oBusBE), .oBusWData(oBusWData),
    .iBusAck(iBusAck), .iBusRData(iBusRData)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one access; slave acks after `waits` unacked REQ cycles. Returns in DONE/FAULT.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] rdat, input int waits);
    iMemRead = rd; iMemWrite = wr; iAddr = a; iFunct3 = f3; iWData = wd;
    #1;
    stall0 = oStall;
    reqCycles = 0; reqAll = 1'b1; lat = 0;
    step();
    lat = 1;
    while (oStall && lat < BOUND) begin
      if (reqCycles == 0) begin
        capWe = oBusWe; capAddr = oBusAddr; capBE = oBusBE; capWData = oBusWData;
      end
      reqAll = reqAll & oBusReq;
      if (reqCycles == waits) begin
        iBusAck = 1'b1; iBusRData = rdat;
      end
      reqCycles++;
      step();
      lat++;
      iBusAck = 1'b0;
    end
    chk("access_bound", 32'(lat >= BOUND), 32'd0);
    iMemRead = 1'b0; iMemWrite = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iMemRead = 1'b1; iMemWrite = 1'b0; iAddr = '0; iWData = '0;
    iFunct3 = F3_W; iBusAck = 1'b0; iBusRData = '0;
    #12;
    chk("rst_stall", 32'(oStall), 32'd0);
    chk("rst_busreq", 32'(oBusReq), 32'd0);
    chk("rst_mdr", oMDR, 32'd0);
    chk("rst_be", 32'(oBusBE), 32'd0);
    chk("rst_misalign", 32'(oMisalign), 32'd0);
    chk("rst_buserr", 32'(oBusErr), 32'd0);
    iMemRead = 1'b0;
    step();
    iRST = 1'b0;
    step();

    // LW, zero-wait slave
    access(1'b1, 1'b0, 32'h100, F3_W, 32'h0, 32'hDEADBEEF, 0);
    chk("lw_stall_c0", 32'(stall0), 32'd1);
    chk("lw_latency", 32'(lat), 32'd2);
    chk("lw_mdr", oMDR, 32'hDEADBEEF);
    chk("lw_addr", capAddr, 32'h100);
    chk("lw_be", 32'(capBE), 32'hF);
    chk("lw_we", 32'(capWe), 32'd0);
    chk("lw_done_req", 32'(oBusReq), 32'd0);
    chk("lw_done_stall", 32'(oStall), 32'd0);
    step();

    access(1'b1, 1'b0, 32'h103, F3_B, 32'h0, 32'h80112233, 0);
    chk("lb_103", oMDR, 32'hFFFFFF80);
    step();
    access(1'b1, 1'b0, 32'h103, F3_BU, 32'h0, 32'h80112233, 0);
    chk("lbu_103", oMDR, 32'h00000080);
    step();
    access(1'b1, 1'b0, 32'h102, F3_HU, 32'h0, 32'h80112233, 0);
    chk("lhu_102", oMDR, 32'h00008011);
    step();
    access(1'b1, 1'b0, 32'h102, F3_H, 32'h0, 32'h80112233, 0);
    chk("lh_102", oMDR, 32'hFFFF8011);
    step();
    access(1'b1, 1'b0, 32'h100, F3_H, 32'h0, 32'h80112233, 0);
    chk("lh_100", oMDR, 32'h00002233);
    step();
    access(1'b1, 1'b0, 32'h101, F3_B, 32'h0, 32'h80112233, 0);
    chk("lb_101", oMDR, 32'h00000022);
    step();

    // Two wait states add two cycles
    access(1'b1, 1'b0, 32'h104, F3_W, 32'h0, 32'h12345678, 2);
    chk("lw_wait2_lat", 32'(lat), 32'd4);
    chk("lw_wait2_mdr", oMDR, 32'h12345678);
    step();

    access(1'b0, 1'b1, 32'h206, F3_H, 32'h0000ABCD, 32'hFFFFFFFF, 0);
    chk("sh_we", 32'(capWe), 32'd1);
    chk("sh_addr", capAddr, 32'h204);
    chk("sh_be", 32'(capBE), 32'hC);
    chk("sh_wdata", capWData, 32'hABCDABCD);
    chk("sh_mdr_keep", oMDR, 32'h12345678);
    step();
    access(1'b0, 1'b1, 32'h204, F3_H, 32'h00001234, 32'h0, 0);
    chk("sh_lo_be", 32'(capBE), 32'h3);
    step();
    access(1'b0, 1'b1, 32'h201, F3_B, 32'h0000005A, 32'h0, 0);
    chk("sb_be", 32'(capBE), 32'h2);
    chk("sb_wdata", capWData, 32'h5A5A5A5A);
    step();
    access(1'b0, 1'b1, 32'h208, F3_W, 32'hCAFEF00D, 32'h0, 1);
    chk("sw_be", 32'(capBE), 32'hF);
    chk("sw_wdata", capWData, 32'hCAFEF00D);
    chk("sw_lat", 32'(lat), 32'd3);
    step();

    // Misaligned / illegal requests
    access(1'b1, 1'b0, 32'h101, F3_W, 32'h0, 32'h0, 0);
    chk("mis_lw_lat", 32'(lat), 32'd1);
    chk("mis_lw_noreq", 32'(reqCycles), 32'd0);
    chk("mis_lw_pulse", 32'(oMisalign), 32'd1);
    chk("mis_lw_buserr", 32'(oBusErr), 32'd0);
    chk("mis_lw_mdr", oMDR, 32'h12345678);
    step();
    chk("mis_lw_pulse_end", 32'(oMisalign), 32'd0);
    access(1'b1, 1'b0, 32'h103, F3_H, 32'h0, 32'h0, 0);
    chk("mis_lh", 32'(oMisalign), 32'd1);
    step();
    access(1'b1, 1'b0, 32'h100, 3'b011, 32'h0, 32'h0, 0);
    chk("ill_f3_011", 32'(oMisalign), 32'd1);
    step();
    access(1'b1, 1'b1, 32'h100, F3_W, 32'h0, 32'h0, 0);
    chk("ill_rd_wr", 32'(oMisalign), 32'd1);
    chk("ill_rd_wr_noreq", 32'(reqCycles), 32'd0);
    step();

    // Slave never acks
    access(1'b1, 1'b0, 32'h300, F3_W, 32'h0, 32'h0, 1000);
    chk("to_req_cycles", 32'(reqCycles), 32'(TO));
    chk("to_req_all", 32'(reqAll), 32'd1);
    chk("to_lat", 32'(lat), 32'(TO + 1));
    chk("to_buserr", 32'(oBusErr), 32'd1);
    chk("to_misalign", 32'(oMisalign), 32'd0);
    chk("to_fault_req", 32'(oBusReq), 32'd0);
    chk("to_mdr", oMDR, 32'h12345678);
    step();
    chk("to_buserr_end", 32'(oBusErr), 32'd0);
    chk("to_idle_stall", 32'(oStall), 32'd0);

    // Reset in the middle of a waiting REQ
    iMemRead = 1'b1; iAddr = 32'h400; iFunct3 = F3_W;
    step();
    chk("rr_req1", 32'(oBusReq), 32'd1);
    step();
    chk("rr_req2", 32'(oBusReq), 32'd1);
    #1 iRST = 1'b1;
    #1;
    chk("rr_req_drop", 32'(oBusReq), 32'd0);
    chk("rr_stall_rst", 32'(oStall), 32'd0);
    iMemRead = 1'b0; iBusAck = 1'b1; iBusRData = 32'hBAD0BAD0;
    step();
    step();
    iRST = 1'b0;
    step();
    chk("rr_late_ack_req", 32'(oBusReq), 32'd0);
    chk("rr_late_ack_mdr", oMDR, 32'd0);
    chk("rr_late_ack_stall", 32'(oStall), 32'd0);
    chk("rr_late_ack_err", 32'(oBusErr), 32'd0);
    iBusAck = 1'b0;
    step();
    access(1'b1, 1'b0, 32'h104, F3_W, 32'h0, 32'h13579BDF, 1);
    chk("rr_fresh_lat", 32'(lat), 32'd3);
    chk("rr_fresh_mdr", oMDR, 32'h13579BDF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
